enemy_sprite_renderer: RTL

Pixel-pipeline stage directly upstream of the enemy sprite ROM, and also its consumer. For each incoming screen pixel it decides whether the pixel falls inside the enemy's 32x32 bounding box and drives the ROM address. It registers the returned 24-bit colour and applies a transparency key. A small per-enemy life FSM (alive / hit-flash / dead) gates visibility, and the output feeds the frame compositor.

---
 rtl/enemy_render_pkg.sv | 19 +
 rtl/enemy_life_fsm.sv | 82 ++++++++
 rtl/enemy_sprite_renderer.sv | 115 +++++++++++
 3 files changed

// File: rtl/enemy_render_pkg.sv
// Shared types and defaults for the enemy sprite renderer and its life FSM.
package enemy_render_pkg;

    typedef enum logic [1:0] {
        DEAD  = 2'd0,
        ALIVE = 2'd1,
        FLASH = 2'd2
    } enemy_state_t;

    localparam int unsigned DEF_ADDRESS         = 10;
    localparam int unsigned SPRITE_LOG2         = DEF_ADDRESS / 2;
    localparam int unsigned FLASH_CNT_BITS      = 8;
    localparam logic [23:0] DEF_TRANSPARENT_KEY = 24'hFF00FF;

    function automatic int unsigned sprite_log2(input int unsigned addr_w);
        return addr_w / 2;
    endfunction

endpackage

// File: rtl/enemy_life_fsm.sv
// Per-enemy life FSM (dead / alive / hit-flash). Visibility only changes on frame_tick so a
// frame is never drawn half-visible; alive tracks the state register directly.
module enemy_life_fsm
    import enemy_render_pkg::*;
#(
    parameter int unsigned FLASH_FRAMES = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_frame_tick,
    input  logic i_spawn,
    input  logic i_kill,
    output logic o_alive,
    output logic o_visible
);

    localparam logic [FLASH_CNT_BITS-1:0] FLASH_LAST = FLASH_CNT_BITS'(FLASH_FRAMES - 1);

    enemy_state_t              r_state;
    enemy_state_t              w_state_next;
    logic [FLASH_CNT_BITS-1:0] r_flash_cnt;
    logic [FLASH_CNT_BITS-1:0] w_flash_cnt_next;
    logic                      r_visible;
    logic                      w_visible_next;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= DEAD;
            r_flash_cnt <= '0;
            r_visible   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_flash_cnt <= w_flash_cnt_next;
            r_visible   <= w_visible_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_flash_cnt_next = r_flash_cnt;
        w_visible_next   = r_visible;

        unique case (r_state)
            DEAD: begin
                if (i_spawn) begin
                    w_state_next = ALIVE;
                end
            end
            ALIVE: begin
                // kill has priority over a simultaneous spawn
                if (i_kill) begin
                    w_state_next     = FLASH;
                    w_flash_cnt_next = '0;
                end
            end
            FLASH: begin
                if (i_frame_tick) begin
                    w_flash_cnt_next = r_flash_cnt + 1'b1;
                    if (r_flash_cnt == FLASH_LAST) begin
                        w_state_next = DEAD;
                    end
                end
            end
            default: begin
                w_state_next = DEAD;
            end
        endcase

        // Visibility for the coming frame is taken from the post-tick state.
        if (i_frame_tick) begin
            unique case (w_state_next)
                ALIVE:   w_visible_next = 1'b1;
                FLASH:   w_visible_next = ~w_flash_cnt_next[0];
                default: w_visible_next = 1'b0;
            endcase
        end
    end

    assign o_alive   = (r_state == ALIVE);
    assign o_visible = r_visible;

endmodule

// File: rtl/enemy_sprite_renderer.sv
// Two-stage enemy sprite pixel pipeline: box test + ROM address, then colour key and visibility.
// Define ENEMY_SCALE2X_EN to draw each texel 2x2 (64x64 on-screen box, same latency).
module enemy_sprite_renderer
    import enemy_render_pkg::*;
#(
    parameter int unsigned            ADDRESS         = DEF_ADDRESS,
    parameter int unsigned            COLOR_BITS      = 24,
    parameter int unsigned            COORD_BITS      = 10,
    parameter logic [COLOR_BITS-1:0]  TRANSPARENT_KEY = COLOR_BITS'(DEF_TRANSPARENT_KEY),
    parameter int unsigned            FLASH_FRAMES    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_tick,
    input  logic                  pix_valid,
    input  logic [COORD_BITS-1:0] pix_x,
    input  logic [COORD_BITS-1:0] pix_y,
    input  logic [COORD_BITS-1:0] enemy_x,
    input  logic [COORD_BITS-1:0] enemy_y,
    input  logic                  spawn,
    input  logic                  kill,
    output logic [ADDRESS-1:0]    rom_addr,
    input  logic [COLOR_BITS-1:0] rom_dout,
    output logic                  px_valid,
    output logic                  px_hit,
    output logic [COLOR_BITS-1:0] px_rgb,
    output logic                  alive
);

    localparam int unsigned SPR_LOG2 = sprite_log2(ADDRESS);
`ifdef ENEMY_SCALE2X_EN
    localparam int unsigned BOX_LOG2 = SPR_LOG2 + 1;
`else
    localparam int unsigned BOX_LOG2 = SPR_LOG2;
`endif
    localparam logic [COORD_BITS:0] BOX_SIDE = (COORD_BITS + 1)'(1 << BOX_LOG2);

    logic [COORD_BITS-1:0] r_pos_x;
    logic [COORD_BITS-1:0] r_pos_y;
    logic                  r_v1;
    logic                  r_in_box;
    logic [ADDRESS-1:0]    r_rom_addr;
    logic                  r_px_valid;
    logic                  r_px_hit;
    logic [COLOR_BITS-1:0] r_px_rgb;

    logic [COORD_BITS:0]   w_dx;
    logic [COORD_BITS:0]   w_dy;
    logic                  w_in_box;
    logic [ADDRESS-1:0]    w_addr;
    logic                  w_hit_next;
    logic                  w_visible;
    logic                  w_alive;

    enemy_life_fsm #(
        .FLASH_FRAMES (FLASH_FRAMES)
    ) u_life_fsm (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_frame_tick (frame_tick),
        .i_spawn      (spawn),
        .i_kill       (kill),
        .o_alive      (w_alive),
        .o_visible    (w_visible)
    );

    // Widened subtract: a pixel left of/above the sprite gives a huge dx/dy, never a wrap.
    always_comb begin
        w_dx     = {1'b0, pix_x} - {1'b0, r_pos_x};
        w_dy     = {1'b0, pix_y} - {1'b0, r_pos_y};
        w_in_box = (pix_x >= r_pos_x) && (w_dx < BOX_SIDE) &&
                   (pix_y >= r_pos_y) && (w_dy < BOX_SIDE);
`ifdef ENEMY_SCALE2X_EN
        w_addr   = {w_dy[SPR_LOG2:1], w_dx[SPR_LOG2:1]};
`else
        w_addr   = {w_dy[SPR_LOG2-1:0], w_dx[SPR_LOG2-1:0]};
`endif
    end

    assign w_hit_next = r_in_box & w_visible & (rom_dout != TRANSPARENT_KEY);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pos_x    <= '0;
            r_pos_y    <= '0;
            r_v1       <= 1'b0;
            r_in_box   <= 1'b0;
            r_rom_addr <= '0;
            r_px_valid <= 1'b0;
            r_px_hit   <= 1'b0;
            r_px_rgb   <= '0;
        end else begin
            // Position only moves between frames to avoid tearing.
            if (frame_tick) begin
                r_pos_x <= enemy_x;
                r_pos_y <= enemy_y;
            end
            r_v1     <= pix_valid;
            r_in_box <= pix_valid & w_in_box;
            if (pix_valid) begin
                r_rom_addr <= w_in_box ? w_addr : '0;
            end
            r_px_valid <= r_v1;
            r_px_hit   <= w_hit_next;
            r_px_rgb   <= w_hit_next ? rom_dout : '0;
        end
    end

    assign rom_addr = r_rom_addr;
    assign px_valid = r_px_valid;
    assign px_hit   = r_px_hit;
    assign px_rgb   = r_px_rgb;
    assign alive    = w_alive;

endmodule
